// File: rtl/lcd1602_ctrlmod.sv
// LCD1602 upstream sequencer: powers up, sends the HD44780 init commands,
// then refreshes both display lines from a 32-byte host-writable buffer,
// one byte per call/done handshake with the byte-writer.
module lcd1602_ctrlmod #(
    parameter int unsigned POWERUP_DELAY = 1000,
    parameter int unsigned REFRESH_GAP   = 100,
    parameter logic [7:0]  FUNC_SET      = 8'h38,
    parameter logic [7:0]  DISP_CTRL     = 8'h0C,
    parameter logic [7:0]  ENTRY_MODE    = 8'h06,
    parameter logic [7:0]  CLEAR_CMD     = 8'h01
) (
    input  logic       CLOCK,
    input  logic       RST_n,
    output logic       oCall,
    output logic       oRS,
    output logic [7:0] oDATA,
    input  logic       iDone,
    input  logic       iWrEn,
    input  logic [4:0] iWrAddr,
    input  logic [7:0] iWrData,
    output logic       oReady,
    output logic       oFrame
);

    localparam logic [19:0] PWR_CNT = 20'(POWERUP_DELAY);
    localparam logic [19:0] GAP_CNT = 20'(REFRESH_GAP);

    typedef enum logic [2:0] {PWR_WAIT, INIT, ADDR1, LINE1, ADDR2, LINE2, GAP} state_t;

    state_t      r_state, w_state_nxt;
    logic [19:0] r_cnt, w_cnt_nxt;
    logic [4:0]  r_idx, w_idx_nxt;
    logic        r_call, w_call_nxt;
    logic        r_rs, w_rs_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_frame, w_frame_nxt;
    logic        w_go;
    logic [7:0]  r_buf [32];

    // Character buffer: all spaces after reset, host writes commit on the clock edge
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
        end else if (iWrEn) begin
            r_buf[iWrAddr] <= iWrData;
        end
    end

    // Sequencer state and registered handshake outputs
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= PWR_WAIT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_call  <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_call  <= w_call_nxt;
            r_rs    <= w_rs_nxt;
            r_data  <= w_data_nxt;
            r_ready <= w_ready_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    // Next state; a byte is launched (w_go) on the edge after a wait expires or
    // one cycle after the previous iDone, so oCall always drops for a cycle.
    // The buffer is read combinationally at launch, so a same-edge host write
    // is not seen until the next refresh.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_call_nxt  = r_call;
        w_rs_nxt    = r_rs;
        w_data_nxt  = r_data;
        w_ready_nxt = r_ready;
        w_frame_nxt = 1'b0;
        w_go        = 1'b0;
        case (r_state)
            PWR_WAIT: begin
                if (r_cnt >= PWR_CNT) begin
                    w_state_nxt = INIT;
                    w_cnt_nxt   = '0;
                    w_go        = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
            GAP: begin
                if (r_cnt >= GAP_CNT) begin
                    w_state_nxt = ADDR1;
                    w_cnt_nxt   = '0;
                    w_go        = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
            default: begin
                if (!r_call) begin
                    w_go = 1'b1;
                end else if (iDone) begin
                    w_call_nxt = 1'b0;
                    case (r_state)
                        INIT: begin
                            if (r_idx == 5'd3) begin
                                w_ready_nxt = 1'b1;
                                w_state_nxt = ADDR1;
                                w_idx_nxt   = '0;
                            end else begin
                                w_idx_nxt = r_idx + 5'd1;
                            end
                        end
                        ADDR1: begin
                            w_state_nxt = LINE1;
                            w_idx_nxt   = '0;
                        end
                        LINE1: begin
                            w_idx_nxt = r_idx + 5'd1;
                            if (r_idx == 5'd15) w_state_nxt = ADDR2;
                        end
                        ADDR2: w_state_nxt = LINE2;
                        LINE2: begin
                            w_idx_nxt = r_idx + 5'd1;  // 31 wraps to 0
                            if (r_idx == 5'd31) begin
                                w_frame_nxt = 1'b1;
                                w_state_nxt = GAP;
                                w_cnt_nxt   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        if (w_go) begin
            w_call_nxt = 1'b1;
            case (w_state_nxt)
                INIT: begin
                    w_rs_nxt = 1'b0;
                    case (w_idx_nxt[1:0])
                        2'd0:    w_data_nxt = FUNC_SET;
                        2'd1:    w_data_nxt = DISP_CTRL;
                        2'd2:    w_data_nxt = ENTRY_MODE;
                        default: w_data_nxt = CLEAR_CMD;
                    endcase
                end
                ADDR1: begin
                    w_rs_nxt   = 1'b0;
                    w_data_nxt = 8'h80;
                end
                ADDR2: begin
                    w_rs_nxt   = 1'b0;
                    w_data_nxt = 8'hC0;
                end
                default: begin
                    w_rs_nxt   = 1'b1;
                    w_data_nxt = r_buf[w_idx_nxt];
                end
            endcase
        end
    end

    assign oCall  = r_call;
    assign oRS    = r_rs;
    assign oDATA  = r_data;
    assign oReady = r_ready;
    assign oFrame = r_frame;

endmodule
